// File: rtl/controlador_memoria.sv
`default_nettype none
// ============================================================================
// == Module      : controlador_memoria                                      ==
// == Description : Single-transaction memory controller. Accepts one read   ==
// ==               or write request at a time, drives a synchronous memory  ==
// ==               port and returns a response through a valid/ready        ==
// ==               handshake.                                               ==
// == Optional    : VERIFICA_ESCRITA_EN - every write is followed by a       ==
// ==               read-back of the same address; the response carries the  ==
// ==               read-back value and flags a mismatch on resp_erro.       ==
// == Revision    : 1.0 - initial release                                    ==
// ============================================================================
// Ports
//   clk                 : clock, all state changes on the rising edge
//   reset               : asynchronous reset, active low
//   req_valido          : request present
//   req_pronto          : controller can accept a request (idle only)
//   req_escrita         : 1 = write, 0 = read
//   req_endereco        : target address
//   req_dado            : write data
//   resp_valido         : response available
//   resp_pronto         : consumer takes the response
//   resp_dado           : read data, or echoed / read-back write data
//   resp_erro           : write-verify mismatch flag
//   mem_endereco        : memory address
//   mem_valor_escrita   : memory write data
//   mem_leitura         : memory read strobe
//   mem_escrita         : memory write strobe
//   mem_valor_saida     : memory read data, updated by the memory on the
//                         rising edge at which mem_leitura = 1
// ============================================================================

module controlador_memoria #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valido,
   output logic              req_pronto,
   input  logic              req_escrita,
   input  logic [ADDR_W-1:0] req_endereco,
   input  logic [DATA_W-1:0] req_dado,
   output logic              resp_valido,
   input  logic              resp_pronto,
   output logic [DATA_W-1:0] resp_dado,
   output logic              resp_erro,
   output logic [ADDR_W-1:0] mem_endereco,
   output logic [DATA_W-1:0] mem_valor_escrita,
   output logic              mem_leitura,
   output logic              mem_escrita,
   input  logic [DATA_W-1:0] mem_valor_saida
);

   typedef enum logic [2:0] {
      OCIOSO   = 3'd0,
      ESCRITA  = 3'd1,
      LEITURA  = 3'd2,
      CAPTURA  = 3'd3,
      RESPOSTA = 3'd4
   } t_estado;

   t_estado            r_estado;
   logic               r_req_pronto;
   logic               r_resp_valido;
   logic [DATA_W-1:0]  r_resp_dado;
   logic [ADDR_W-1:0]  r_mem_endereco;
   logic [DATA_W-1:0]  r_mem_valor_escrita;
   logic               r_mem_leitura;
   logic               r_mem_escrita;
   // Write data captured at acceptance; the request inputs are free to
   // change while the transaction is in flight.
   logic [DATA_W-1:0]  r_dado;
`ifdef VERIFICA_ESCRITA_EN
   logic               r_escrita;
   logic               r_resp_erro;
`endif

   // The address is held in r_mem_endereco from acceptance until the last
   // memory access of the transaction, so it doubles as the latched address.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_estado            <= OCIOSO;
         r_req_pronto        <= 1'b0;
         r_resp_valido       <= 1'b0;
         r_resp_dado         <= '0;
         r_mem_endereco      <= '0;
         r_mem_valor_escrita <= '0;
         r_mem_leitura       <= 1'b0;
         r_mem_escrita       <= 1'b0;
         r_dado              <= '0;
`ifdef VERIFICA_ESCRITA_EN
         r_escrita           <= 1'b0;
         r_resp_erro         <= 1'b0;
`endif
      end else begin
         case (r_estado)
            OCIOSO: begin
               // r_req_pronto is 0 in the first idle cycle after reset, so
               // acceptance is gated on the registered flag, not the state.
               r_req_pronto <= 1'b1;
               if (req_valido && r_req_pronto) begin
                  r_req_pronto   <= 1'b0;
                  r_dado         <= req_dado;
                  r_mem_endereco <= req_endereco;
`ifdef VERIFICA_ESCRITA_EN
                  r_escrita      <= req_escrita;
`endif
                  if (req_escrita) begin
                     r_estado            <= ESCRITA;
                     r_mem_escrita       <= 1'b1;
                     r_mem_valor_escrita <= req_dado;
                  end else begin
                     r_estado      <= LEITURA;
                     r_mem_leitura <= 1'b1;
                  end
               end
            end

            ESCRITA: begin
               r_mem_escrita       <= 1'b0;
               r_mem_valor_escrita <= '0;
`ifdef VERIFICA_ESCRITA_EN
               // Read back the location just written; address is kept.
               r_estado      <= LEITURA;
               r_mem_leitura <= 1'b1;
`else
               r_estado       <= RESPOSTA;
               r_mem_endereco <= '0;
               r_resp_valido  <= 1'b1;
               r_resp_dado    <= r_dado;
`endif
            end

            LEITURA: begin
               // The memory presents the data during the following cycle.
               r_estado       <= CAPTURA;
               r_mem_leitura  <= 1'b0;
               r_mem_endereco <= '0;
            end

            CAPTURA: begin
               r_estado      <= RESPOSTA;
               r_resp_valido <= 1'b1;
               r_resp_dado   <= mem_valor_saida;
`ifdef VERIFICA_ESCRITA_EN
               r_resp_erro   <= r_escrita && (mem_valor_saida != r_dado);
`endif
            end

            RESPOSTA: begin
               if (resp_pronto) begin
                  r_estado      <= OCIOSO;
                  r_req_pronto  <= 1'b1;
                  r_resp_valido <= 1'b0;
                  r_resp_dado   <= '0;
`ifdef VERIFICA_ESCRITA_EN
                  r_resp_erro   <= 1'b0;
`endif
               end
            end

            default: begin
               r_estado      <= OCIOSO;
               r_req_pronto  <= 1'b0;
               r_resp_valido <= 1'b0;
               r_mem_leitura <= 1'b0;
               r_mem_escrita <= 1'b0;
            end
         endcase
      end
   end

   assign req_pronto        = r_req_pronto;
   assign resp_valido       = r_resp_valido;
   assign resp_dado         = r_resp_dado;
   assign mem_endereco      = r_mem_endereco;
   assign mem_valor_escrita = r_mem_valor_escrita;
   assign mem_leitura       = r_mem_leitura;
   assign mem_escrita       = r_mem_escrita;
`ifdef VERIFICA_ESCRITA_EN
   assign resp_erro         = r_resp_erro;
`else
   assign resp_erro         = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_controlador_memoria.sv
`default_nettype none
// ============================================================================
// == Module      : tb_controlador_memoria                                   ==
// == Description : Self-checking bench for controlador_memoria with a       ==
// ==               synchronous memory model and a transaction-level         ==
// ==               reference model. Honours VERIFICA_ESCRITA_EN.            ==
// == Revision    : 1.0 - initial release                                    ==
// ============================================================================

module tb_controlador_memoria;

   localparam int AW = 3;
   localparam int DW = 8;
`ifdef VERIFICA_ESCRITA_EN
   localparam bit c_verif = 1'b1;
`else
   localparam bit c_verif = 1'b0;
`endif
   // Response latency counted in cycles after the accepting edge.
   localparam int c_lat_wr = c_verif ? 4 : 2;
   localparam int c_lat_rd = 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valido = 1'b0;
   logic          req_pronto;
   logic          req_escrita = 1'b0;
   logic [AW-1:0] req_endereco = '0;
   logic [DW-1:0] req_dado = '0;
   logic          resp_valido;
   logic          resp_pronto = 1'b0;
   logic [DW-1:0] resp_dado;
   logic          resp_erro;
   logic [AW-1:0] mem_endereco;
   logic [DW-1:0] mem_valor_escrita;
   logic          mem_leitura;
   logic          mem_escrita;
   logic [DW-1:0] mem_valor_saida = '0;

   int total = 0;
   int bad   = 0;

   controlador_memoria #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk               (clk),
      .reset             (reset),
      .req_valido        (req_valido),
      .req_pronto        (req_pronto),
      .req_escrita       (req_escrita),
      .req_endereco      (req_endereco),
      .req_dado          (req_dado),
      .resp_valido       (resp_valido),
      .resp_pronto       (resp_pronto),
      .resp_dado         (resp_dado),
      .resp_erro         (resp_erro),
      .mem_endereco      (mem_endereco),
      .mem_valor_escrita (mem_valor_escrita),
      .mem_leitura       (mem_leitura),
      .mem_escrita       (mem_escrita),
      .mem_valor_saida   (mem_valor_saida)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Memory content as seen through a read; in verify builds address 2 is
   // a faulty cell that returns inverted data.
   function automatic logic [DW-1:0] mread(input logic [DW-1:0] v, input logic [AW-1:0] a);
      return (c_verif && a == 3'd2) ? ~v : v;
   endfunction

   // ---------------- memory attached to the controller ----------------
   logic [DW-1:0] mem [8] = '{default: '0};
   always @(posedge clk) begin
      if (mem_escrita) mem[mem_endereco] <= mem_valor_escrita;
      if (mem_leitura) mem_valor_saida   <= mread(mem[mem_endereco], mem_endereco);
   end

   // ---------------- transaction-level reference model ----------------
   logic [DW-1:0] ref_mem [8] = '{default: '0};
   logic          m_ready = 1'b0;
   logic          m_busy  = 1'b0;
   int            m_k     = 0;     // cycle index within the transaction
   int            m_lat   = 0;
   logic          m_w     = 1'b0;
   logic [AW-1:0] m_addr  = '0;
   logic [DW-1:0] m_wdata = '0;
   logic [DW-1:0] m_rdata = '0;
   logic          m_err   = 1'b0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_ready <= 1'b0;
         m_busy  <= 1'b0;
         m_k     <= 0;
      end else if (m_busy) begin
         if (m_k >= m_lat && resp_pronto) begin
            m_busy  <= 1'b0;
            m_ready <= 1'b1;
         end else begin
            m_k <= m_k + 1;
         end
      end else if (!m_ready) begin
         m_ready <= 1'b1;
      end else if (req_valido) begin
         m_busy  <= 1'b1;
         m_ready <= 1'b0;
         m_k     <= 1;
         m_w     <= req_escrita;
         m_addr  <= req_endereco;
         m_wdata <= req_dado;
         if (req_escrita) begin
            ref_mem[req_endereco] <= req_dado;
            m_lat   <= c_lat_wr;
            m_rdata <= c_verif ? mread(req_dado, req_endereco) : req_dado;
            m_err   <= c_verif && (mread(req_dado, req_endereco) != req_dado);
         end else begin
            m_lat   <= c_lat_rd;
            m_rdata <= mread(ref_mem[req_endereco], req_endereco);
            m_err   <= 1'b0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (!reset) begin
         chk("rst_req_pronto",  req_pronto,        0);
         chk("rst_resp_valido", resp_valido,       0);
         chk("rst_resp_dado",   resp_dado,         0);
         chk("rst_resp_erro",   resp_erro,         0);
         chk("rst_mem_end",     mem_endereco,      0);
         chk("rst_mem_wdata",   mem_valor_escrita, 0);
         chk("rst_mem_leitura", mem_leitura,       0);
         chk("rst_mem_escrita", mem_escrita,       0);
      end else begin : cmp
         logic e_esc, e_lei, e_rv;
         e_esc = m_busy && m_w && m_k == 1;
         e_lei = m_busy && ((!m_w && m_k == 1) || (m_w && c_verif && m_k == 2));
         e_rv  = m_busy && m_k >= m_lat;
         chk("req_pronto",  req_pronto,  m_ready && !m_busy);
         chk("mem_escrita", mem_escrita, e_esc);
         chk("mem_leitura", mem_leitura, e_lei);
         chk("resp_valido", resp_valido, e_rv);
         if (e_esc) begin
            chk("mem_end_wr",  mem_endereco,      m_addr);
            chk("mem_wdata",   mem_valor_escrita, m_wdata);
         end
         if (e_lei) chk("mem_end_rd", mem_endereco, m_addr);
         if (e_rv) begin
            chk("resp_dado", resp_dado, m_rdata);
            chk("resp_erro", resp_erro, m_err);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic wait_ready();
      for (int i = 0; i < 20; i++) begin
         if (m_ready && !m_busy) return;
         @(negedge clk);
      end
      chk("ready_timeout", 0, 1);
   endtask

   // One transaction with literal expectations; the request inputs are
   // scrambled right after acceptance and resp_pronto is withheld for
   // 'hold' response cycles while an extra request is offered.
   task automatic xact(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] ed, input logic ee, input int el, input int hold);
      int            lat;
      logic [DW-1:0] held;
      wait_ready();
      req_valido = 1'b1; req_escrita = w; req_endereco = a; req_dado = d;
      resp_pronto = 1'b0;
      @(posedge clk); #1;
      req_valido = 1'b0; req_escrita = ~w; req_endereco = ~a; req_dado = ~d;
      lat = 0;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (resp_valido) begin
            lat = i;
            break;
         end
      end
      chk("x_latency",   lat,       el);
      chk("x_resp_dado", resp_dado, ed);
      chk("x_resp_erro", resp_erro, ee);
      held = resp_dado;
      for (int i = 0; i < hold; i++) begin
         req_valido = 1'b1;
         @(negedge clk);
         chk("hold_valido", resp_valido, 1);
         chk("hold_dado",   resp_dado,   held);
         chk("hold_pronto", req_pronto,  0);
      end
      req_valido  = 1'b0;
      resp_pronto = 1'b1;
      @(negedge clk);
      resp_pronto = 1'b0;
      chk("done_valido", resp_valido, 0);
      chk("done_pronto", req_pronto,  1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      chk("rel_pronto0", req_pronto, 0);
      @(negedge clk);
      chk("rel_pronto1", req_pronto, 1);

      xact(1'b1, 3'd1, 8'hAA, 8'hAA, 1'b0, c_lat_wr, 0);
      chk("model_mem1", ref_mem[1], 8'hAA);
      xact(1'b0, 3'd1, 8'h00, 8'hAA, 1'b0, 3, 3);
      xact(1'b1, 3'd7, 8'h55, 8'h55, 1'b0, c_lat_wr, 0);
      xact(1'b1, 3'd0, 8'h0F, 8'h0F, 1'b0, c_lat_wr, 1);
      xact(1'b0, 3'd7, 8'hFF, 8'h55, 1'b0, 3, 0);
      xact(1'b0, 3'd0, 8'hFF, 8'h0F, 1'b0, 3, 2);
`ifdef VERIFICA_ESCRITA_EN
      xact(1'b1, 3'd2, 8'h3C, 8'hC3, 1'b1, 4, 0);
`else
      xact(1'b1, 3'd2, 8'h3C, 8'h3C, 1'b0, 2, 0);
`endif

      // Reset during the read strobe cycle aborts the transaction.
      wait_ready();
      req_valido = 1'b1; req_escrita = 1'b0; req_endereco = 3'd1;
      @(posedge clk); #1;
      req_valido = 1'b0;
      chk("abort_pre_leitura", mem_leitura, 1);
      reset = 1'b0;
      #1;
      chk("abort_leitura", mem_leitura, 0);
      chk("abort_valido",  resp_valido, 0);
      chk("abort_pronto",  req_pronto,  0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      chk("abort_rel0", req_pronto, 0);
      @(negedge clk);
      chk("abort_rel1", req_pronto, 1);

      // Randomized traffic, including back-to-back requests and
      // resp_pronto toggling outside the response phase.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         req_valido   = 1'($urandom_range(0, 1));
         req_escrita  = 1'($urandom_range(0, 1));
         req_endereco = 3'($urandom_range(0, 7));
         req_dado     = 8'($urandom);
         resp_pronto  = ($urandom_range(0, 3) != 0);
      end
      req_valido  = 1'b0;
      resp_pronto = 1'b1;
      repeat (8) @(negedge clk);
      chk("final_idle", m_busy, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
